twiddle_requant_stage: RTL

//  Downstream stage of the CSD twiddle multiplier in the N=128 FFT datapath.
//  - Accepts full-precision complex products {real,imag}, NBITS_IN bits each.
//  - Removes the coefficient scale 2^SHIFT with round-half-up.
//  - Saturates each component back to NBITS.
//  - Registers the result in a 2-stage valid/ready pipeline feeding the next butterfly.
//  - Tags frame boundaries and counts saturation events.

---
 rtl/twiddle_requant_stage.sv | 99 +++++++++
 1 files changed

// File: rtl/twiddle_requant_stage.sv
// twiddle_requant_stage: round-half-up / saturate CSD twiddle products to NBITS,
// two-deep valid/ready register stage with frame-last tagging and saturation count.
module twiddle_requant_stage #(
    parameter int NBITS     = 12,
    parameter int NBITS_IN  = 24,
    parameter int SHIFT     = 9,
    parameter int FRAME_LEN = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*NBITS_IN-1:0] din,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*NBITS-1:0]    dout,
    output logic                  out_last,
    output logic                  sat_flag,
    input  logic                  sat_clr,
    output logic [15:0]           sat_count
);

    localparam int W    = NBITS_IN + 1;
    localparam int LCNT = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic signed [W-1:0] HALF = W'(2 ** (SHIFT - 1));
    localparam logic signed [W-1:0] MAXV = W'(2 ** (NBITS - 1) - 1);
    localparam logic signed [W-1:0] MINV = W'(-(2 ** (NBITS - 1)));
    localparam logic [LCNT-1:0]     LAST = LCNT'(FRAME_LEN - 1);

    logic                  s1_valid;
    logic [2*NBITS_IN-1:0] s1_data;
    logic                  s2_valid;
    logic [LCNT-1:0]       fcnt;
    logic                  adv2;
    logic [NBITS:0]        rq_re;
    logic [NBITS:0]        rq_im;

    // Returns {sat, value}; sign-extension by one bit keeps x + HALF from wrapping.
    function automatic logic [NBITS:0] requant(input logic [NBITS_IN-1:0] x);
        logic signed [W-1:0] s;
        logic signed [W-1:0] q;
        s = $signed({x[NBITS_IN-1], x}) + HALF;
        q = s >>> SHIFT;
        if (q > MAXV)
            requant = {1'b1, 1'b0, {(NBITS-1){1'b1}}};
        else if (q < MINV)
            requant = {1'b1, 1'b1, {(NBITS-1){1'b0}}};
        else
            requant = {1'b0, q[NBITS-1:0]};
    endfunction

    assign rq_re     = requant(s1_data[2*NBITS_IN-1:NBITS_IN]);
    assign rq_im     = requant(s1_data[NBITS_IN-1:0]);
    assign adv2      = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || !s2_valid || out_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            if (in_ready)
                s1_valid <= in_valid;
            if (in_valid && in_ready)
                s1_data <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            dout     <= '0;
            out_last <= 1'b0;
            sat_flag <= 1'b0;
            fcnt     <= '0;
        end else begin
            if (!s2_valid || out_ready)
                s2_valid <= s1_valid;
            if (adv2) begin
                dout     <= {rq_re[NBITS-1:0], rq_im[NBITS-1:0]};
                sat_flag <= rq_re[NBITS] | rq_im[NBITS];
                out_last <= (fcnt == LAST);
                fcnt     <= fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_count <= '0;
        else if (sat_clr)
            sat_count <= '0;
        else if (s2_valid && out_ready && sat_flag && sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
    end

endmodule
